// File: rtl/dct_pkg.sv
// Shared definitions for the avalon_dct master-side job sequencer.
package dct_pkg;

    localparam int NBITS = 16;

    localparam int DCT_ADDR_SIZE = 0;
    localparam int DCT_ADDR_DATA = 1;
    localparam int DCT_ADDR_FRAC = 2;

    typedef enum logic [2:0] {
        IDLE,
        CFG_M,
        CFG_SIZE,
        LOAD,
        RD_REQ,
        EMIT,
        DONE
    } seq_state_t;

    // A transform size is usable when 1 <= L <= max_log2.
    function automatic logic log2_ok(input logic [3:0] l, input int max_log2);
        return (l != 4'd0) && (int'(l) <= max_log2);
    endfunction

endpackage

// File: rtl/dct_job_sequencer_if.sv
// Job control, sample/coefficient streams and avalon_dct master bus of the sequencer.
interface dct_job_sequencer_if #(
    parameter int NBITS    = 16,
    parameter int MAX_LOG2 = 5,
    parameter int ADDR_W   = 8
);
    logic [4:0]          cfg_int_bits;
    logic [3:0]          cfg_log2_size;
    logic                job_start;
    logic                job_busy;
    logic                job_done;
    logic                cfg_err;

    logic [NBITS-1:0]    s_data;
    logic                s_valid;
    logic                s_ready;

    logic [NBITS-1:0]    c_data;
    logic [MAX_LOG2-1:0] c_index;
    logic                c_valid;
    logic                c_ready;

    logic [ADDR_W-1:0]   dct_addr;
    logic                dct_read;
    logic                dct_write;
    logic [NBITS-1:0]    dct_writedata;
    logic [NBITS-1:0]    dct_readdata;
    logic                dct_done;

    // Sequencer side: masters the avalon_dct bus, sinks samples, sources coefficients.
    modport master (
        input  cfg_int_bits, cfg_log2_size, job_start,
        input  s_data, s_valid, c_ready, dct_readdata, dct_done,
        output job_busy, job_done, cfg_err, s_ready,
        output c_data, c_index, c_valid,
        output dct_addr, dct_read, dct_write, dct_writedata
    );

    modport slave (
        output cfg_int_bits, cfg_log2_size, job_start,
        output s_data, s_valid, c_ready, dct_readdata, dct_done,
        input  job_busy, job_done, cfg_err, s_ready,
        input  c_data, c_index, c_valid,
        input  dct_addr, dct_read, dct_write, dct_writedata
    );

endinterface

// File: rtl/dct_job_sequencer.sv
// Runs one avalon_dct job per start: configure, stream 2**L samples in, read 2**L coefficients out.
//
// state    | meaning
// IDLE     | waiting for job_start; validates L
// CFG_M    | write integer-bit count M to the fraction register
// CFG_SIZE | write L to the size register
// LOAD     | pass accepted samples straight through to the data register
// RD_REQ   | read coefficient k, wait for dct_done
// EMIT     | hold coefficient k on the output stream until taken
// DONE     | one-cycle job_done
module dct_job_sequencer
    import dct_pkg::*;
#(
    parameter int NBITS    = dct_pkg::NBITS,
    parameter int MAX_LOG2 = 5,
    parameter int ADDR_W   = 8
) (
    input  logic Clock,
    input  logic reset,
    dct_job_sequencer_if.master bus
);

    localparam int CW = MAX_LOG2 + 1;

    seq_state_t          state_q, state_d;
    logic [CW-1:0]       k_q, k_d;
    logic [4:0]          m_q;
    logic [3:0]          l_q;
    logic [NBITS-1:0]    c_data_q;
    logic [MAX_LOG2-1:0] c_index_q;
    logic                c_valid_q;
    logic                cfg_err_q;

    logic                cfg_ok;
    logic                start_ok;
    logic [CW-1:0]       k_last;

    assign cfg_ok   = log2_ok(bus.cfg_log2_size, MAX_LOG2);
    assign start_ok = (state_q == IDLE) && bus.job_start && cfg_ok;
    assign k_last   = CW'((1 << l_q) - 1);

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            m_q       <= '0;
            l_q       <= '0;
            c_data_q  <= '0;
            c_index_q <= '0;
            c_valid_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cfg_err_q <= (state_q == IDLE) && bus.job_start && !cfg_ok;
            if (start_ok) begin
                m_q <= bus.cfg_int_bits;
                l_q <= bus.cfg_log2_size;
            end
            if (state_q == RD_REQ && bus.dct_done) begin
                c_data_q  <= bus.dct_readdata;
                c_index_q <= k_q[MAX_LOG2-1:0];
                c_valid_q <= 1'b1;
            end else if (state_q == EMIT && bus.c_ready) begin
                c_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        k_d               = k_q;
        bus.dct_addr      = '0;
        bus.dct_read      = 1'b0;
        bus.dct_write     = 1'b0;
        bus.dct_writedata = '0;
        bus.s_ready       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_ok) state_d = CFG_M;
            end
            CFG_M: begin
                bus.dct_write     = 1'b1;
                bus.dct_addr      = ADDR_W'(DCT_ADDR_FRAC);
                bus.dct_writedata = NBITS'(m_q);
                state_d           = CFG_SIZE;
            end
            CFG_SIZE: begin
                bus.dct_write     = 1'b1;
                bus.dct_addr      = ADDR_W'(DCT_ADDR_SIZE);
                bus.dct_writedata = NBITS'(l_q);
                state_d           = LOAD;
            end
            LOAD: begin
                bus.dct_addr      = ADDR_W'(DCT_ADDR_DATA);
                bus.s_ready       = 1'b1;
                bus.dct_write     = bus.s_valid;
                bus.dct_writedata = bus.s_data;
                if (bus.s_valid) begin
                    if (k_q == k_last) begin
                        k_d     = '0;
                        state_d = RD_REQ;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            RD_REQ: begin
                bus.dct_read = 1'b1;
                bus.dct_addr = ADDR_W'(k_q);
                if (bus.dct_done) state_d = EMIT;
            end
            // Read stays low here so a dct_done held high is never captured twice.
            EMIT: begin
                if (c_valid_q && bus.c_ready) begin
                    if (k_q == k_last) begin
                        k_d     = '0;
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.job_busy = (state_q != IDLE);
    assign bus.job_done = (state_q == DONE);
    assign bus.cfg_err  = cfg_err_q;
    assign bus.c_data   = c_data_q;
    assign bus.c_index  = c_index_q;
    assign bus.c_valid  = c_valid_q;

endmodule

// File: tb/tb_dct_job_sequencer.sv
// Self-checking bench: behavioural avalon_dct slave, stream source/sink and job-level reference model.
module tb_dct_job_sequencer;

    localparam int NB = 16;
    localparam int ML = 5;
    localparam int AW = 8;

    logic Clock = 1'b0;
    logic reset;
    always #5 Clock = ~Clock;

    dct_job_sequencer_if #(.NBITS(NB), .MAX_LOG2(ML), .ADDR_W(AW)) bus();

    dct_job_sequencer #(.NBITS(NB), .MAX_LOG2(ML), .ADDR_W(AW)) dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference DCT-II, averaged over n and rounded to the nearest integer.
    function automatic int dct_coef(input int xs[$], input int k);
        real acc;
        int  n;
        int  r;
        acc = 0.0;
        n   = xs.size();
        for (int i = 0; i < n; i++)
            acc += xs[i] * $cos(3.14159265358979 * ((2 * i + 1) * k) / (2.0 * n));
        acc = acc / n;
        r = (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(-acc + 0.5);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // avalon_dct slave model
    int          slv_samples[$];
    int          slv_coef[32];
    int          slv_n = 0;
    int          lat = 0;
    logic        done_q = 1'b0;
    logic        tie_done = 1'b0;
    logic [15:0] rd_q = '0;

    always @(posedge Clock) begin
        if (!reset && bus.dct_write) begin
            if (bus.dct_addr == 8'd0) begin
                slv_n <= 1 << bus.dct_writedata[3:0];
                slv_samples.delete();
            end else if (bus.dct_addr == 8'd1) begin
                slv_samples.push_back(int'($signed(bus.dct_writedata)));
                if (slv_samples.size() == slv_n)
                    for (int k = 0; k < slv_n; k++) slv_coef[k] <= dct_coef(slv_samples, k);
            end
        end
        done_q <= 1'b0;
        if (bus.dct_read && !done_q) begin
            if (lat == 0) begin
                done_q <= 1'b1;
                rd_q   <= 16'(slv_coef[bus.dct_addr[4:0]]);
                lat    <= $urandom_range(0, 3);
            end else begin
                lat <= lat - 1;
            end
        end
    end

    assign bus.dct_readdata = tie_done ? 16'(slv_coef[bus.dct_addr[4:0]]) : rd_q;
    assign bus.dct_done     = tie_done | done_q;

    // Observation of transfers, sampled mid-cycle
    int wr_addr[$], wr_dat[$], out_idx[$], out_dat[$];
    int done_cnt = 0, err_cnt = 0, busy_cnt = 0, rw_both = 0;

    always @(negedge Clock) begin
        if (!reset) begin
            if (bus.dct_write) begin
                wr_addr.push_back(int'(bus.dct_addr));
                wr_dat.push_back(int'(bus.dct_writedata));
            end
            if (bus.c_valid && bus.c_ready) begin
                out_idx.push_back(int'(bus.c_index));
                out_dat.push_back(int'($signed(bus.c_data)));
            end
            if (bus.job_done) done_cnt <= done_cnt + 1;
            if (bus.cfg_err) err_cnt <= err_cnt + 1;
            if (bus.job_busy) busy_cnt <= busy_cnt + 1;
            if (bus.dct_read && bus.dct_write) rw_both <= rw_both + 1;
        end
    end

    task automatic start_job(input int m, input int l);
        @(posedge Clock); #1;
        bus.cfg_int_bits  = 5'(m);
        bus.cfg_log2_size = 4'(l);
        bus.job_start     = 1'b1;
        @(posedge Clock); #1;
        bus.job_start     = 1'b0;
    endtask

    task automatic run_job(input string name, input int m, input int l, input int xs[$],
                           input bit toggle, input int stall_k, input bit tie);
        int n;
        int d0;
        int ex[$];
        n  = 1 << l;
        d0 = done_cnt;
        wr_addr.delete(); wr_dat.delete(); out_idx.delete(); out_dat.delete();
        for (int k = 0; k < n; k++) ex.push_back(dct_coef(xs, k));
        tie_done = tie;
        start_job(m, l);
        fork
            begin
                int idx = 0;
                int cyc = 0;
                bit v;
                while (idx < n && cyc < 2000) begin
                    v = toggle ? (cyc % 2 == 0) : 1'b1;
                    bus.s_valid = v;
                    bus.s_data  = 16'(xs[idx]);
                    @(negedge Clock);
                    if (v && bus.s_ready) idx++;
                    @(posedge Clock); #1;
                    cyc++;
                end
                bus.s_valid = 1'b0;
                n_checks++;
                if (idx != n) begin
                    n_fail++;
                    $display("FAIL %s source: accepted %0d samples, expected %0d", name, idx, n);
                end
            end
            begin
                int  cyc = 0;
                bit  stalled = 0;
                bus.c_ready = 1'b1;
                while (done_cnt == d0 && cyc < 4000) begin
                    @(posedge Clock); #1;
                    cyc++;
                    if (stall_k >= 0 && !stalled && bus.c_valid && int'(bus.c_index) == stall_k) begin
                        stalled = 1;
                        bus.c_ready = 1'b0;
                        repeat (10) begin
                            @(negedge Clock);
                            n_checks++;
                            if (bus.c_valid !== 1'b1 || int'($signed(bus.c_data)) != ex[stall_k] ||
                                bus.dct_read !== 1'b0 || int'(bus.c_index) != stall_k) begin
                                n_fail++;
                                $display("FAIL %s stall hold: valid=%b data=%0d idx=%0d read=%b, expected 1/%0d/%0d/0",
                                         name, bus.c_valid, $signed(bus.c_data), bus.c_index, bus.dct_read,
                                         ex[stall_k], stall_k);
                            end
                        end
                        @(posedge Clock); #1;
                        bus.c_ready = 1'b1;
                    end
                end
                n_checks++;
                if (done_cnt == d0) begin
                    n_fail++;
                    $display("FAIL %s timeout: job_done not seen, expected within budget", name);
                end
            end
        join
        tie_done = 1'b0;
        repeat (2) @(posedge Clock);
        #1;

        n_checks++;
        if (wr_addr.size() != n + 2) begin
            n_fail++;
            $display("FAIL %s write count: got %0d expected %0d", name, wr_addr.size(), n + 2);
        end else begin
            n_checks++;
            if (wr_addr[0] != 2 || wr_dat[0] != m || wr_addr[1] != 0 || wr_dat[1] != l) begin
                n_fail++;
                $display("FAIL %s config writes: got (%0d:%0d),(%0d:%0d) expected (2:%0d),(0:%0d)",
                         name, wr_addr[0], wr_dat[0], wr_addr[1], wr_dat[1], m, l);
            end
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (wr_addr[i + 2] != 1 || wr_dat[i + 2] != (xs[i] & 32'hFFFF)) begin
                    n_fail++;
                    $display("FAIL %s sample %0d: got (%0d:%0d) expected (1:%0d)",
                             name, i, wr_addr[i + 2], wr_dat[i + 2], xs[i] & 32'hFFFF);
                end
            end
        end

        n_checks++;
        if (out_idx.size() != n) begin
            n_fail++;
            $display("FAIL %s coefficient count: got %0d expected %0d", name, out_idx.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (out_idx[i] != i || out_dat[i] != ex[i]) begin
                    n_fail++;
                    $display("FAIL %s coef %0d: got idx %0d data %0d expected idx %0d data %0d",
                             name, i, out_idx[i], out_dat[i], i, ex[i]);
                end
            end
        end

        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL %s job_done pulses: got %0d expected 1", name, done_cnt - d0);
        end
    endtask

    function automatic void rand_samples(input int n, output int xs[$]);
        xs.delete();
        for (int i = 0; i < n; i++) xs.push_back(int'($urandom_range(0, 65535)) - 32768);
    endfunction

    task automatic test_reset();
        logic [6:0] flags;
        reset = 1'b1;
        bus.cfg_int_bits = '0; bus.cfg_log2_size = '0; bus.job_start = 1'b0;
        bus.s_data = '0; bus.s_valid = 1'b0; bus.c_ready = 1'b0;
        #3;
        flags = {bus.job_busy, bus.job_done, bus.cfg_err, bus.s_ready, bus.c_valid, bus.dct_read, bus.dct_write};
        n_checks++;
        if (flags !== 7'd0) begin
            n_fail++;
            $display("FAIL reset flags: got %b expected 0000000", flags);
        end
        n_checks++;
        if (bus.dct_addr !== '0 || bus.dct_writedata !== '0 || bus.c_data !== '0 || bus.c_index !== '0) begin
            n_fail++;
            $display("FAIL reset buses: got addr %0h wd %0h cdata %0h cidx %0h expected all 0",
                     bus.dct_addr, bus.dct_writedata, bus.c_data, bus.c_index);
        end
        repeat (2) @(negedge Clock);
        reset = 1'b0;
        @(posedge Clock); #1;
    endtask

    task automatic test_cos_ramp();
        int  xs[$];
        int  sum;
        real v;
        sum = 0;
        for (int i = 0; i < 32; i++) begin
            v = 4096.0 * $cos(3.14159265358979 * i / 32.0);
            xs.push_back(v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5));
            sum += xs[i];
        end
        run_job("cos_ramp", 6, 5, xs, 1'b0, -1, 1'b0);
        n_checks++;
        if (out_dat.size() == 0) begin
            n_fail++;
            $display("FAIL cos_ramp dc: no coefficient observed, expected %0d", sum / 32);
        end else if (out_dat[0] - sum / 32 > 2 || sum / 32 - out_dat[0] > 2) begin
            n_fail++;
            $display("FAIL cos_ramp dc: got %0d expected %0d +/-2", out_dat[0], sum / 32);
        end
    endtask

    task automatic test_cfg_err();
        int bad_l[2] = '{0, 6};
        for (int t = 0; t < 2; t++) begin
            int e0, b0, w0;
            e0 = err_cnt; b0 = busy_cnt; w0 = wr_addr.size();
            start_job(3, bad_l[t]);
            repeat (3) @(posedge Clock);
            #1;
            n_checks++;
            if (err_cnt - e0 != 1 || busy_cnt != b0 || wr_addr.size() != w0) begin
                n_fail++;
                $display("FAIL cfg_err L=%0d: got err %0d busy %0d writes %0d expected 1 0 0",
                         bad_l[t], err_cnt - e0, busy_cnt - b0, wr_addr.size() - w0);
            end
        end
    endtask

    task automatic test_toggle_valid();
        int xs[$];
        rand_samples(8, xs);
        run_job("toggle_valid", int'($urandom_range(0, 15)), 3, xs, 1'b1, -1, 1'b0);
    endtask

    task automatic test_stall();
        int xs[$];
        rand_samples(8, xs);
        run_job("stall", 4, 3, xs, 1'b0, 2, 1'b0);
    endtask

    task automatic test_tied_done();
        int xs[$];
        rand_samples(8, xs);
        run_job("tied_done", 5, 3, xs, 1'b0, -1, 1'b1);
    endtask

    task automatic test_reset_in_load();
        int         xs[$];
        int         cnt, cyc, d0;
        logic [6:0] flags;
        rand_samples(8, xs);
        wr_addr.delete(); wr_dat.delete();
        d0 = done_cnt;
        start_job(2, 3);
        cnt = 0; cyc = 0;
        bus.s_valid = 1'b1;
        while (cnt < 4 && cyc < 50) begin
            bus.s_data = 16'(xs[cnt]);
            @(negedge Clock);
            if (bus.s_ready) cnt++;
            @(posedge Clock); #1;
            cyc++;
        end
        bus.s_valid = 1'b0;
        bus.s_data  = 16'hA5A5;
        #2 reset = 1'b1;
        #1;
        flags = {bus.job_busy, bus.job_done, bus.cfg_err, bus.s_ready, bus.c_valid, bus.dct_read, bus.dct_write};
        n_checks++;
        if (flags !== 7'd0 || bus.dct_addr !== '0 || bus.dct_writedata !== '0 ||
            bus.c_data !== '0 || bus.c_index !== '0) begin
            n_fail++;
            $display("FAIL reset_in_load outputs: got flags %b addr %0h wd %0h expected all 0",
                     flags, bus.dct_addr, bus.dct_writedata);
        end
        n_checks++;
        if (wr_addr.size() != 6) begin
            n_fail++;
            $display("FAIL reset_in_load writes before reset: got %0d expected 6", wr_addr.size());
        end
        repeat (2) @(negedge Clock);
        reset = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        n_checks++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL reset_in_load abandoned job_done: got %0d expected 0", done_cnt - d0);
        end
        rand_samples(4, xs);
        run_job("after_reset", 1, 2, xs, 1'b0, -1, 1'b0);
    endtask

    task automatic test_random_jobs();
        int xs[$];
        int l;
        for (int t = 0; t < 3; t++) begin
            l = (t == 0) ? 1 : int'($urandom_range(1, ML));
            rand_samples(1 << l, xs);
            run_job("random_job", int'($urandom_range(0, 15)), l, xs, $urandom_range(0, 1) == 1, -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_cos_ramp();
        test_cfg_err();
        test_toggle_valid();
        test_stall();
        test_tied_done();
        test_reset_in_load();
        test_random_jobs();
        n_checks++;
        if (rw_both != 0) begin
            n_fail++;
            $display("FAIL read_write_exclusive: got %0d overlap cycles expected 0", rw_both);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
